// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel magnitude stage: border size, width helpers
// and the stage-1 payload layout.
package sobel_pkg;

  localparam int unsigned BORDER_C = 2;
  localparam int unsigned PIX_W_C  = 8;
  localparam int unsigned GRAD_W_C = 2 * PIX_W_C;

  function automatic int unsigned grad_width(input int unsigned pix_w);
    return 2 * pix_w;
  endfunction

  // Two's-complement absolute value; the most negative code maps to 2^(GRAD_W_C-1).
  function automatic logic [GRAD_W_C-1:0] abs_grad(input logic [GRAD_W_C-1:0] g);
    return g[GRAD_W_C-1] ? (~g + GRAD_W_C'(1)) : g;
  endfunction

  typedef struct packed {
    logic                mask;
    logic                eol;
    logic                eof;
    logic [GRAD_W_C-1:0] ax;
    logic [GRAD_W_C-1:0] ay;
  } s1_payload_t;

endpackage

// File: rtl/sobel_mag_stage.sv
// Elastic pipeline register: loads when empty or when its content leaves
// in the same cycle, holds while downstream stalls.
module sobel_mag_stage #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data
);

  assign up_ready = ~dn_valid | dn_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/sobel_mag.sv
// L1 Sobel gradient magnitude with border masking and raster markers.
// Optional binary edge map output when SOBEL_MAG_THRESH_EN is defined.
module sobel_mag
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH_P = PIX_W_C,
  parameter int unsigned COLS_P  = 16,
  parameter int unsigned ROWS_P  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2*WIDTH_P-1:0]   gx_i,
  input  logic [2*WIDTH_P-1:0]   gy_i,
  input  logic [WIDTH_P-1:0]     thresh_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH_P-1:0]     data_o,
  output logic                   eol_o,
  output logic                   eof_o
);

  localparam int unsigned GW = grad_width(WIDTH_P);
  localparam int unsigned CW = (COLS_P > 1) ? $clog2(COLS_P) : 1;
  localparam int unsigned RW = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          beat;
  logic          s1_ready, s1_valid, s2_ready, s2_valid;
  s1_payload_t   s1_in, s1_q;
  logic [GW:0]   sum;
  logic [WIDTH_P-1:0] mag, pix;
  logic [WIDTH_P+1:0] s2_in, s2_q;

  assign ready_o = ~rst_i & s1_ready;
  assign beat    = valid_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      if (col == CW'(COLS_P - 1)) begin
        col <= '0;
        row <= (row == RW'(ROWS_P - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_comb begin
    s1_in      = '0;
    s1_in.mask = (row < RW'(BORDER_C)) | (col < CW'(BORDER_C));
    s1_in.eol  = (col == CW'(COLS_P - 1));
    s1_in.eof  = s1_in.eol & (row == RW'(ROWS_P - 1));
    s1_in.ax   = abs_grad(gx_i);
    s1_in.ay   = abs_grad(gy_i);
  end

  sobel_mag_stage #(.DATA_W($bits(s1_payload_t))) u_stage1 (
    .clk      (clk_i),
    .rst_n    (~rst_i),
    .up_valid (valid_i),
    .up_ready (s1_ready),
    .up_data  (s1_in),
    .dn_valid (s1_valid),
    .dn_ready (s2_ready),
    .dn_data  (s1_q)
  );

  // Saturate whenever any bit above the pixel width is set.
  always_comb begin
    sum = {1'b0, s1_q.ax} + {1'b0, s1_q.ay};
    mag = (|sum[GW:WIDTH_P]) ? '1 : sum[WIDTH_P-1:0];
`ifdef SOBEL_MAG_THRESH_EN
    pix = (!s1_q.mask && (mag >= thresh_i)) ? '1 : '0;
`else
    pix = s1_q.mask ? '0 : mag;
`endif
    s2_in = {pix, s1_q.eol, s1_q.eof};
  end

`ifndef SOBEL_MAG_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
`endif

  sobel_mag_stage #(.DATA_W(WIDTH_P + 2)) u_stage2 (
    .clk      (clk_i),
    .rst_n    (~rst_i),
    .up_valid (s1_valid),
    .up_ready (s2_ready),
    .up_data  (s2_in),
    .dn_valid (s2_valid),
    .dn_ready (ready_i),
    .dn_data  (s2_q)
  );

  assign valid_o = s2_valid;
  assign {data_o, eol_o, eof_o} = s2_q;

endmodule

// File: tb/tb_sobel_mag.sv
// Self-checking bench for sobel_mag: vector table, latency/stall/reset sequences
// and a random handshake phase, all checked through an expected-pixel queue.
module tb_sobel_mag;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;
  localparam int unsigned R = 4;
  localparam int THRESH = 50;

  logic clk = 1'b0;
  logic rst_i, valid_i, ready_o, ready_i, valid_o, eol_o, eof_o;
  logic signed [2*W-1:0] gx_i, gy_i;
  logic [W-1:0] thresh_i, data_o;

  sobel_mag #(.WIDTH_P(W), .COLS_P(C), .ROWS_P(R)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .gx_i     (gx_i),
    .gy_i     (gy_i),
    .thresh_i (thresh_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .eol_o    (eol_o),
    .eof_o    (eof_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         eol;
    logic         eof;
  } pix_t;

  typedef struct {
    logic signed [15:0] gx;
    logic signed [15:0] gy;
    int                 mag;
  } vec_t;

  pix_t        sb[$];
  vec_t        tbl[32];
  int          n_vec = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int unsigned m_row = 0;
  int unsigned m_col = 0;
  logic        was_stalled = 1'b0;
  logic [W+1:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] expect_pix(input int mag, input logic masked);
`ifdef SOBEL_MAG_THRESH_EN
    return (!masked && mag >= THRESH) ? 8'd255 : 8'd0;
`else
    return masked ? 8'd0 : 8'(mag);
`endif
  endfunction

  function automatic int sat_mag(input logic signed [15:0] gx, input logic signed [15:0] gy);
    int a, b;
    a = gx;
    b = gy;
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic push_expected(input int mag);
    pix_t p;
    logic masked;
    masked = (m_row < 2) || (m_col < 2);
    p.data = expect_pix(mag, masked);
    p.eol  = (m_col == C - 1);
    p.eof  = p.eol && (m_row == R - 1);
    sb.push_back(p);
    if (m_col == C - 1) begin
      m_col = 0;
      m_row = (m_row == R - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic monitor();
    if (rst_i) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled) begin
        check("hold_valid", valid_o, 1);
        check("hold_pixel", {data_o, eol_o, eof_o}, held);
      end
      was_stalled = valid_o && !ready_i;
      held = {data_o, eol_o, eof_o};
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("extra_pixel", valid_o & ready_i, 0);
        end else begin
          check("pix_data", data_o, sb[0].data);
          check("pix_eol", eol_o, sb[0].eol);
          check("pix_eof", eof_o, sb[0].eof);
          void'(sb.pop_front());
        end
      end
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, return after the rising edge.
  task automatic cycle_drive(input logic v, input logic signed [15:0] gx,
                             input logic signed [15:0] gy, input int mag, output logic took);
    valid_i = v;
    gx_i = gx;
    gy_i = gy;
    @(negedge clk);
    monitor();
    took = v && ready_o;
    if (took) push_expected(mag);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic signed [15:0] gx, input logic signed [15:0] gy, input int mag);
    logic took;
    for (int i = 0; i < 100; i++) begin
      cycle_drive(1'b1, gx, gy, mag, took);
      if (took) return;
    end
    check("beat_timeout", ready_o, 1);
  endtask

  task automatic drain();
    logic took;
    ready_i = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) cycle_drive(1'b0, 0, 0, 0, took);
    cycle_drive(1'b0, 0, 0, 0, took);
    cycle_drive(1'b0, 0, 0, 0, took);
    check("drain_empty", sb.size(), 0);
    check("drain_idle", valid_o, 0);
  endtask

  initial begin
    logic took;
    int   cnt;
    int   c0;
    logic signed [15:0] rgx, rgy;

    tbl[0]  = '{5, 5, 10};          tbl[1]  = '{200, 0, 200};
    tbl[2]  = '{-1, 1, 2};          tbl[3]  = '{100, 100, 200};
    tbl[4]  = '{0, 0, 0};           tbl[5]  = '{7, -8, 15};
    tbl[6]  = '{49, 0, 49};         tbl[7]  = '{-100, -100, 200};
    tbl[8]  = '{300, -300, 255};    tbl[9]  = '{1, 1, 2};
    tbl[10] = '{-30, 45, 75};       tbl[11] = '{200, 100, 255};
    tbl[12] = '{20, 29, 49};        tbl[13] = '{-3, -4, 7};
    tbl[14] = '{-32768, -32768, 255}; tbl[15] = '{0, -255, 255};
    tbl[16] = '{1, 2, 3};           tbl[17] = '{3, 4, 7};
    tbl[18] = '{255, 0, 255};       tbl[19] = '{-5, 0, 5};
    tbl[20] = '{0, 0, 0};           tbl[21] = '{9, 9, 18};
    tbl[22] = '{128, 127, 255};     tbl[23] = '{100, -27, 127};
    tbl[24] = '{-1, -1, 2};         tbl[25] = '{200, 0, 200};
    tbl[26] = '{20, 29, 49};        tbl[27] = '{-25, -25, 50};
    tbl[28] = '{64, 64, 128};       tbl[29] = '{0, 1, 1};
    tbl[30] = '{0, 255, 255};       tbl[31] = '{32767, -1, 255};

    rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    gx_i = '0; gy_i = '0; thresh_i = 8'(THRESH);

    for (int i = 0; i < 3; i++) begin
      cycle_drive(1'b1, 7, 7, 14, took);
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 0);
      check("rst_eol", eol_o, 0);
      check("rst_eof", eof_o, 0);
      check("rst_ready", ready_o, 0);
    end
    rst_i = 1'b0;
    valid_i = 1'b0;
    #1;
    check("release_ready", ready_o, 1);

    // Two frames of hand-computed magnitudes; first beat lands at row 0, col 0.
    for (int i = 0; i < 32; i++) drive_beat(tbl[i].gx, tbl[i].gy, tbl[i].mag);
    drain();

    // Latency: single beat at row 2 / col 2 into an empty pipe.
    for (int i = 0; i < 10; i++) drive_beat(0, 0, 0);
    drain();
    drive_beat(-30, 45, 75);
    check("lat_cycle1_valid", valid_o, 0);
    cycle_drive(1'b0, 0, 0, 0, took);
    check("lat_cycle2_valid", valid_o, 1);
    check("lat_cycle2_data", data_o, expect_pix(75, 1'b0));
    for (int i = 0; i < 5; i++) drive_beat(0, 0, 0);
    drain();

    // Border mask and markers over two back-to-back frames.
    c0 = cyc;
    for (int i = 0; i < 32; i++) drive_beat(10, 10, 20);
    check("throughput_cycles", cyc - c0, 32);
    drain();

    // Backpressure: stalled beats land on interior pixels (row 2, cols 2-3).
    for (int i = 0; i < 10; i++) drive_beat(0, 0, 0);
    drain();
    ready_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b1, 16'(i + 1), 0, i + 1, took);
      cnt += int'(took);
    end
    check("stall_beats", cnt, 2);
    check("stall_ready", ready_o, 0);
    drain();

    for (int i = 0; i < 400; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      rgx = 16'(int'($urandom_range(0, 300)) - 150);
      rgy = 16'(int'($urandom_range(0, 300)) - 150);
      cycle_drive(1'($urandom_range(0, 1)), rgx, rgy, sat_mag(rgx, rgy), took);
    end
    drain();

    // Reset mid-frame with beats in flight.
    for (int i = 0; i < 6; i++) drive_beat(10, 10, 20);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle_drive(1'b1, 10, 10, 20, took);
    rst_i = 1'b1;
    sb.delete();
    m_row = 0;
    m_col = 0;
    cycle_drive(1'b0, 0, 0, 0, took);
    cycle_drive(1'b0, 0, 0, 0, took);
    check("midrst_valid", valid_o, 0);
    check("midrst_data", data_o, 0);
    check("midrst_ready", ready_o, 0);
    rst_i = 1'b0;
    ready_i = 1'b1;
    #1;
    check("midrst_release_ready", ready_o, 1);
    for (int i = 0; i < 16; i++) drive_beat(10, 10, 20);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sobel_mag.md
# sobel_mag

Consumer end of the Sobel gradient stream. It accepts signed gx/gy pairs from the 2-D convolution stage through a valid/ready handshake and computes an L1 gradient magnitude saturated to pixel width. Pixels whose 3x3 window was incomplete at the frame border are masked to zero. Output is a raster pixel stream with end-of-line and end-of-frame markers, ready for the frame writer.

## Interface
- WIDTH_P, 8, output pixel width; gradient inputs are 2*WIDTH_P bits.
- COLS_P, 16, pixels per row; equals the line-buffer depth upstream.
- ROWS_P, 16, rows per frame.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  gradient pair valid.
- ready_o  out  1  block can accept a gradient pair.
- gx_i  in  2*WIDTH_P  signed horizontal gradient.
- gy_i  in  2*WIDTH_P  signed vertical gradient.
- thresh_i  in  WIDTH_P  binarisation threshold; used only with SOBEL_MAG_THRESH_EN.
- valid_o  out  1  output pixel valid.
- ready_i  in  1  downstream accepts pixel.
- data_o  out  WIDTH_P  magnitude pixel.
- eol_o  out  1  pixel is last in its row.
- eof_o  out  1  pixel is last in the frame.

## Operation
- Input beat = valid_i & ready_o. Only input beats advance the col/row counters and enter the pipe.
- col counts 0..COLS_P-1. At COLS_P-1 it wraps to 0 and row increments. row counts 0..ROWS_P-1. At the last pixel both counters wrap to 0 and the next frame starts.
- Stage 1 (registered):
  - ax = |gx_i| and ay = |gy_i|, each as a 2*WIDTH_P-bit unsigned value. The most negative input yields 2^(2*WIDTH_P-1) with no overflow.
  - The stage also captures mask = (row<2)|(col<2), eol = (col==COLS_P-1), and eof = eol&(row==ROWS_P-1).
- Stage 2 (registered):
  - sum = ax+ay at 2*WIDTH_P+1 bits.
  - mag = (sum > 2^WIDTH_P-1) ? 2^WIDTH_P-1 : sum[WIDTH_P-1:0].
  - data_o = mask ? 0 : mag.
  - eol_o and eof_o are carried alongside the pixel.
- Each stage is an elastic register. It loads when empty or when its content leaves in the same cycle, and holds while the next stage stalls.
- ready_o = ~s1_valid | (~s2_valid | ready_i), and is forced low while rst_i is high.
- No beat is dropped or duplicated. Order is preserved.

## Timing
- Reset (rst_i high at a clock edge): both stages empty, counters 0, valid_o=0, data_o=0, eol_o=0, eof_o=0. ready_o is 0 during reset and 1 on the first cycle after release.
- Reset mid-frame discards in-flight pixels and restarts at row 0, col 0.
- Latency is 2 cycles from input beat to valid_o when ready_i stays high. Throughput is 1 pixel/cycle.
- Stall: with ready_i low, the block absorbs at most 2 beats, then ready_o falls in the same cycle the second stage is found full.
- Outputs hold stable while valid_o & ~ready_i.
- Counters update only on input beats. valid_i low cycles and stalls leave them unchanged.

## Configuration
- SOBEL_MAG_THRESH_EN defined: stage 2 outputs data_o = (mask==0 && mag >= thresh_i) ? 2^WIDTH_P-1 : 0, giving a binary edge map. thresh_i is sampled in stage 2.
- Not defined: data_o is the saturated magnitude, and thresh_i is ignored. The port stays present so top-level wiring is identical in both builds.

## Structure
- Shared package sobel_pkg holds:
  - BORDER_C = 2, the incomplete-window rows/cols.
  - Pixel and gradient width helpers.
  - A packed struct for the stage payload: {mask, eol, eof, ax, ay}.
- Sub-module: the existing elastic pipeline stage is the natural building block.
  - Instantiate it once per stage with the packed payload.
  - Drive its active-low reset from ~rst_i.

## Test plan
Bench parameters: WIDTH_P=8, COLS_P=4, ROWS_P=4.
- Reset: hold rst_i high 3 cycles with valid_i=1. Required: valid_o=0, data_o=0, eol_o=0, eof_o=0, ready_o=0. After release, ready_o=1 and the first beat is counted as row 0, col 0.
- Magnitude: at beat row2/col2, drive gx=-30, gy=45. Required: data_o=75 exactly 2 cycles later with ready_i=1.
- Saturation:
  - gx=200, gy=100 -> data_o=255.
  - gx=-32768, gy=-32768 -> data_o=255.
  - gx=0, gy=-255 -> data_o=255.
- Border and markers: stream 2 full frames with gx=gy=10.
  - data_o=20 only at rows 2-3, cols 2-3; all other pixels 0.
  - eol_o on beats 3, 7, 11, 15; eof_o on beat 15.
  - Frame 2 reproduces the same pattern.
- Backpressure: continuous valid_i with ready_i low for 5 cycles.
  - Exactly 2 beats are absorbed, then ready_o=0.
  - After release, all pixels emerge in order with no loss or duplication.
  - Repeat with random valid_i/ready_i, checked against a scoreboard.
- SOBEL_MAG_THRESH_EN build: thresh_i=50.
  - Interior magnitudes 49 and 50 -> data_o 0 and 255.
  - A border pixel with magnitude 200 -> 0.
